// File: rtl/u109_rd_drain.sv
// u109_rd_drain - read-domain drain engine for the U109 clock-crossing FIFO.
// Takes a (start address, length) command, pops longwords from the FIFO,
// stages up to four of them and issues each group on the local bus, either
// as an aligned 4-longword burst or as a single-longword cycle.
//
// Ports
//   rd_clk, rst_rd_n          read clock, synchronous active-low reset
//   cmd_valid/ready/addr/len  command handshake (ready only while idle)
//   fifo_ready/pop/data       FIFO read port (data valid the cycle after a pop)
//   bus_req/gnt               bus arbitration
//   bus_addr/data/burst/last  current longword presented to the bus target
//   bus_ack                   target accepted the current longword
//   busy, done                engine active / one-cycle completion pulse
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a command, cmd_ready high
// FILL  | popping the FIFO until the group (4 or 1 words) is staged
// REQ   | group staged, requesting the bus
// XFER  | bus granted, issuing staged words one per bus_ack
// DONE  | one-cycle done pulse, then back to IDLE

module u109_rd_drain #(
  parameter int LEN_W = 16
) (
  input  logic             rd_clk,
  input  logic             rst_rd_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             fifo_ready,
  output logic             fifo_pop,
  input  logic [31:0]      fifo_data,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic [31:0]      bus_addr,
  output logic [31:0]      bus_data,
  output logic             bus_burst,
  output logic             bus_last,
  input  logic             bus_ack,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_REQ,
    S_XFER,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      addr_q;
  logic [LEN_W-1:0] remaining_q;
  logic [2:0]       target_q;
  logic [2:0]       staged_q;
  logic             in_flight_q;
  logic [1:0]       idx_q;
  logic [31:0]      stage_buf [4];

  logic [2:0]       target_c;
  logic [2:0]       fill_cnt;
  logic             last_c;

  // Group size is chosen fresh on every FILL visit, so a misaligned start
  // walks up to a 16-byte boundary with singles before bursting.
  assign target_c = ((remaining_q >= LEN_W'(4)) && (addr_q[3:2] == 2'b00)) ? 3'd4 : 3'd1;
  assign fill_cnt = staged_q + {2'b00, in_flight_q};
  assign last_c   = ({1'b0, idx_q} == (target_q - 3'd1));
  assign busy     = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    fifo_pop  = 1'b0;
    bus_req   = 1'b0;
    bus_addr  = 32'h0;
    bus_data  = 32'h0;
    bus_burst = 1'b0;
    bus_last  = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d = (cmd_len == '0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        // Count the word still in flight so we never over-pop the group.
        fifo_pop = fifo_ready && (fill_cnt < target_c);
        if (staged_q == target_c) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        // Grant is not re-checked here: once given it is held for the cycle.
        bus_req   = 1'b1;
        bus_addr  = addr_q;
        bus_data  = stage_buf[idx_q];
        bus_burst = (target_q == 3'd4);
        bus_last  = last_c;
        if (bus_ack && last_c) begin
          state_d = (remaining_q != LEN_W'(1)) ? S_FILL : S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (!rst_rd_n) begin
      state_q     <= S_IDLE;
      addr_q      <= 32'h0;
      remaining_q <= '0;
      target_q    <= 3'd1;
      staged_q    <= 3'd0;
      in_flight_q <= 1'b0;
      idx_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      in_flight_q <= fifo_pop;
      if (in_flight_q) begin
        stage_buf[staged_q[1:0]] <= fifo_data;
        staged_q                 <= staged_q + 3'd1;
      end
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q      <= {cmd_addr[31:2], 2'b00};
            remaining_q <= cmd_len;
          end
        end
        S_FILL: begin
          target_q <= target_c;
        end
        S_XFER: begin
          if (bus_ack) begin
            idx_q       <= idx_q + 2'd1;
            addr_q      <= addr_q + 32'd4;
            remaining_q <= remaining_q - LEN_W'(1);
            if (last_c) begin
              idx_q    <= 2'd0;
              staged_q <= 3'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_u109_rd_drain.sv
module tb_u109_rd_drain;

  logic        rd_clk = 1'b0;
  logic        rst_rd_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        fifo_ready;
  logic        fifo_pop;
  logic [31:0] fifo_data;
  logic        bus_req;
  logic        bus_gnt;
  logic [31:0] bus_addr;
  logic [31:0] bus_data;
  logic        bus_burst;
  logic        bus_last;
  logic        bus_ack;
  logic        busy;
  logic        done;

  always #5 rd_clk = ~rd_clk;

  u109_rd_drain #(.LEN_W(16)) dut (
    .rd_clk     (rd_clk),
    .rst_rd_n   (rst_rd_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .fifo_ready (fifo_ready),
    .fifo_pop   (fifo_pop),
    .fifo_data  (fifo_data),
    .bus_req    (bus_req),
    .bus_gnt    (bus_gnt),
    .bus_addr   (bus_addr),
    .bus_data   (bus_data),
    .bus_burst  (bus_burst),
    .bus_last   (bus_last),
    .bus_ack    (bus_ack),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        burst;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] fifo_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  // 0 = always, 1 = toggle / delayed / every 3rd, 2 = random
  int rdy_mode, gnt_mode, ack_mode;

  int          pops, beats, done_cnt, done_cyc, last_beat_cyc;
  int          first_pop, first_req, bad_pop, early_req, ready_err, req_wait;
  logic        pend;
  logic [31:0] popped;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  // Reference: slice the transfer into bus cycles from the address/length
  // rules and give every longword its own data word in FIFO order.
  task automatic build(input logic [31:0] addr, input int len, input bit seq_data);
    logic [31:0] a;
    logic [31:0] d;
    int rem, n, w;
    a = addr & 32'hFFFF_FFFC;
    rem = len;
    w = 0;
    while (rem > 0) begin
      n = (rem >= 4 && a[3:2] == 2'b00) ? 4 : 1;
      for (int k = 0; k < n; k++) begin
        d = seq_data ? (32'hA000_0000 + 32'(w)) : $urandom;
        fifo_q.push_back(d);
        exp_q.push_back('{a: a, d: d, burst: (n == 4), last: (k == n - 1)});
        a = a + 32'd4;
        rem--;
        w++;
      end
    end
  endtask

  task automatic drive_inputs(input int cyc);
    bit en;
    fifo_data = pend ? popped : $urandom;
    pend = 1'b0;
    case (rdy_mode)
      0: en = 1'b1;
      1: en = cyc[0];
      default: en = ($urandom_range(3) != 0);
    endcase
    fifo_ready = (fifo_q.size() > 0) && en;
    case (gnt_mode)
      0: bus_gnt = 1'b1;
      1: bus_gnt = (req_wait >= 5);
      default: bus_gnt = $urandom_range(1);
    endcase
    case (ack_mode)
      0: bus_ack = 1'b1;
      1: bus_ack = (cyc % 3 == 2);
      default: bus_ack = $urandom_range(1);
    endcase
  endtask

  // One clock: observe mid-cycle, then change inputs just after the edge.
  task automatic tb_cycle(input int cyc);
    bit xfer;
    int need;
    @(negedge rd_clk);
    if (fifo_pop && !fifo_ready) bad_pop++;
    if (cmd_ready == busy) ready_err++;
    if (fifo_pop && fifo_ready) begin
      pops++;
      if (first_pop < 0) first_pop = cyc;
      if (fifo_q.size() > 0) begin
        popped = fifo_q.pop_front();
        pend = 1'b1;
      end else bad_pop++;
    end
    xfer = bus_req && (bus_burst || bus_last);
    if (bus_req) begin
      if (first_req < 0) first_req = cyc;
      need = 0;
      foreach (exp_q[i]) begin
        need++;
        if (exp_q[i].last) break;
      end
      if (pops - beats < need) early_req++;
    end
    if (bus_req && !xfer) req_wait++;
    else if (xfer) req_wait = 0;
    if (xfer) begin
      if (exp_q.size() == 0) chk("extra_beat", 1, 0);
      else begin
        chk("bus_addr", bus_addr, exp_q[0].a);
        chk("bus_data", bus_data, exp_q[0].d);
        chk("bus_burst", bus_burst, exp_q[0].burst);
        chk("bus_last", bus_last, exp_q[0].last);
        if (bus_ack) begin
          void'(exp_q.pop_front());
          beats++;
          last_beat_cyc = cyc;
        end
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge rd_clk);
    #1;
    drive_inputs(cyc + 1);
  endtask

  task automatic start_cmd(input logic [31:0] addr, input int len, input bit seq_data);
    build(addr, len, seq_data);
    pops = 0; beats = 0; done_cnt = 0; done_cyc = -1; last_beat_cyc = -1;
    first_pop = -1; first_req = -1; bad_pop = 0; early_req = 0; ready_err = 0;
    req_wait = 0;
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = 16'(len);
    @(negedge rd_clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge rd_clk);
    #1;
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_len   = 16'($urandom);
    drive_inputs(0);
  endtask

  task automatic run_cmd(input logic [31:0] addr, input int len, input bit seq_data,
                         input int exp_first_req);
    start_cmd(addr, len, seq_data);
    for (int c = 0; c < 4000 && done_cnt == 0; c++) tb_cycle(c);
    chk("done_once", done_cnt, 1);
    chk("beats_left", exp_q.size(), 0);
    chk("pop_count", pops, len);
    chk("pop_wo_ready", bad_pop, 0);
    chk("req_before_staged", early_req, 0);
    if (len > 0) begin
      chk("done_latency", done_cyc, last_beat_cyc + 1);
      if (rdy_mode == 0) chk("first_pop_latency", first_pop, 0);
    end else begin
      chk("zero_len_req", first_req, -1);
      chk("zero_len_done_latency", (done_cyc <= 1), 1);
    end
    if (exp_first_req >= 0) chk("fill_to_req", first_req, exp_first_req);
    for (int c = 0; c < 3; c++) begin
      @(negedge rd_clk);
      if (c == 0) begin
        chk("cmd_ready_after_done", cmd_ready, 1);
        chk("busy_after_done", busy, 0);
      end
      if (done) done_cnt++;
      @(posedge rd_clk);
      #1;
    end
    chk("no_second_done", done_cnt, 1);
    chk("cmd_ready_vs_busy", ready_err, 0);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_cmd_ready"}, cmd_ready, 1);
    chk({pfx, "_fifo_pop"}, fifo_pop, 0);
    chk({pfx, "_bus_req"}, bus_req, 0);
    chk({pfx, "_bus_burst"}, bus_burst, 0);
    chk({pfx, "_bus_last"}, bus_last, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_bus_addr"}, bus_addr, 0);
    chk({pfx, "_bus_data"}, bus_data, 0);
  endtask

  initial begin
    rst_rd_n = 1'b0;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    fifo_ready = 1'b1; fifo_data = '0; bus_gnt = 1'b1; bus_ack = 1'b1;
    pend = 1'b0; popped = '0;
    rdy_mode = 0; gnt_mode = 0; ack_mode = 0;
    repeat (2) @(posedge rd_clk);
    #1;
    chk_reset_outputs("reset");
    rst_rd_n = 1'b1;
    @(posedge rd_clk);
    #1;

    // Aligned two-burst transfer; group staged after 5 cycles, REQ the next.
    run_cmd(32'h0000_1000, 8, 1'b1, 6);
    // Misaligned start: two singles, one burst, single tail.
    run_cmd(32'h0000_1008, 7, 1'b0, -1);
    // Low address bits are ignored.
    run_cmd(32'h0000_1803, 5, 1'b0, -1);

    // FIFO starvation.
    rdy_mode = 1;
    run_cmd(32'h0000_3000, 4, 1'b0, -1);
    rdy_mode = 0;

    // Back-pressure on grant and ack.
    gnt_mode = 1; ack_mode = 1;
    run_cmd(32'h0000_4000, 8, 1'b0, -1);
    run_cmd(32'h0000_4004, 9, 1'b0, -1);
    gnt_mode = 0; ack_mode = 0;

    // Zero length and address wrap.
    run_cmd(32'h0000_5000, 0, 1'b0, -1);
    run_cmd(32'hFFFF_FFF8, 4, 1'b0, -1);
    run_cmd(32'hFFFF_FFF8, 6, 1'b0, -1);

    // Reset in the middle of a burst.
    start_cmd(32'h0000_1000, 8, 1'b0);
    for (int c = 0; c < 200 && beats < 2; c++) tb_cycle(c);
    chk("reached_mid_burst", beats, 2);
    rst_rd_n = 1'b0;
    @(posedge rd_clk);
    #1;
    rst_rd_n = 1'b1;
    chk_reset_outputs("mid_reset");
    exp_q.delete();
    fifo_q.delete();
    pend = 1'b0;
    drive_inputs(0);
    run_cmd(32'h0000_2000, 4, 1'b0, -1);

    // Randomized commands under random FIFO/grant/ack behaviour.
    rdy_mode = 2; gnt_mode = 2; ack_mode = 2;
    for (int t = 0; t < 12; t++) begin
      logic [31:0] ra;
      ra = (t % 3 == 0) ? (32'hFFFF_FFC0 | 32'($urandom_range(63))) : $urandom;
      run_cmd(ra, $urandom_range(0, 14), 1'b0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
